// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU port (0)
// and a second master (1), with bounded lock ownership.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [3:0]    we0,
  input  logic [3:0]    we1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] m_daddr,
  output logic [DW-1:0] m_dwdata,
  output logic [3:0]    m_dwe,
  input  logic [DW-1:0] m_drdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} st_t;

  st_t           st;
  logic          last;
  logic [CW-1:0] lock_cnt;
  logic          forced;
  logic          keep;

  always_comb begin
    forced = 1'b0;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if ((st == OWN0 && req1) || (st == OWN1 && req0))
      forced = (lock_cnt >= CMAX);
    if (st == OWN0 && req0 && !forced) begin
      gnt0 = 1'b1;
    end else if (st == OWN1 && req1 && !forced) begin
      gnt1 = 1'b1;
    end else if (forced) begin
      gnt0 = (st == OWN1);
      gnt1 = (st == OWN0);
    end else if (req0 && req1) begin
      // tie goes to whoever was not served last
      gnt0 = last;
      gnt1 = !last;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign keep = (gnt0 && lock0 && req1 && st != OWN1) ||
                (gnt1 && lock1 && req0 && st != OWN0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      if (gnt0) begin
        last <= 1'b0;
        st   <= lock0 ? OWN0 : IDLE;
      end else if (gnt1) begin
        last <= 1'b1;
        st   <= lock1 ? OWN1 : IDLE;
      end else begin
        st   <= IDLE;
      end
      if (keep)
        lock_cnt <= (lock_cnt >= CMAX) ? CMAX : lock_cnt + 1'b1;
      else
        lock_cnt <= '0;
    end
  end

  always_comb begin
    m_daddr  = '0;
    m_dwdata = '0;
    m_dwe    = '0;
    if (gnt0) begin
      m_daddr  = addr0;
      m_dwdata = wdata0;
      m_dwe    = we0;
    end else if (gnt1) begin
      m_daddr  = addr1;
      m_dwdata = wdata1;
      m_dwe    = we1;
    end
  end

  assign rdata0 = gnt0 ? m_drdata : '0;
  assign rdata1 = gnt1 ? m_drdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector table plus scoreboard bench for dmem_arbiter, with a small
// behavioural data memory behind the shared port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [3:0]  we0 = 0, we1 = 0;
  logic        gnt0, gnt1;
  logic [31:0] rdata0, rdata1, m_daddr, m_dwdata, m_drdata;
  logic [3:0]  m_dwe;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .m_daddr(m_daddr),
    .m_dwdata(m_dwdata), .m_dwe(m_dwe), .m_drdata(m_drdata)
  );

  logic [31:0] mem [64];
  logic        addr_ok;
  assign addr_ok = (m_daddr[31:8] == 24'd0) && (m_daddr[1:0] == 2'b00);
  assign m_drdata = addr_ok ? mem[m_daddr[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (!reset && addr_ok)
      for (int b = 0; b < 4; b++)
        if (m_dwe[b]) mem[m_daddr[7:2]][8*b +: 8] <= m_dwdata[8*b +: 8];

  typedef struct {
    logic rst, r0, r1, l0, l1;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0] w0, w1;
    logic eg0, eg1;
  } vec_t;

  typedef struct {
    logic g0, g1;
    logic [31:0] addr, wdata, rd0, rd1;
    logic [3:0] we;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, r0, r1, l0, l1,
                              input logic [31:0] a0, d0,
                              input logic [3:0] w0,
                              input logic [31:0] a1, d1,
                              input logic [3:0] w1,
                              input logic eg0, eg1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    v.a0 = a0; v.d0 = d0; v.w0 = w0;
    v.a1 = a1; v.d1 = d1; v.w1 = w1;
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  // read-only request pattern on the usual two addresses
  function automatic vec_t rd(input logic rst, r0, r1, l0, l1, eg0, eg1);
    return mk(rst, r0, r1, l0, l1, 32'h10, 32'h0, 4'h0,
              32'h20, 32'h0, 4'h0, eg0, eg1);
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    // single writes, read routing, byte enables, idle outputs
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 4'hF,
                      32'h0, 32'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0,
                      32'h20, 32'h12345678, 4'hF, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0,
                      32'h20, 32'h0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h10, 32'hAAAA5555, 4'h3,
                      32'h0, 32'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0,
                      32'h10, 32'h0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'hCAFEF00D, 4'hF,
                      32'h0, 32'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0,
                      32'h0, 32'h0, 4'h0, 0, 0));
    // round robin from reset
    for (int i = 0; i < 6; i++)
      vecs.push_back(rd(i == 0, 1, 1, 0, 0, i % 2 == 0, i % 2 == 1));
    // lock hold limit: 8 grants then forced handover
    for (int i = 0; i < 8; i++) vecs.push_back(rd(i == 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(rd(0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(rd(0, 1, 1, 0, 0, 1, 0));
    // lock release after 3 locked cycles
    for (int i = 0; i < 3; i++) vecs.push_back(rd(i == 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(rd(0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(rd(0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(rd(0, 1, 1, 0, 0, 1, 0));
    // reset in cycle 4 of a lock: counter restarts from zero
    for (int i = 0; i < 3; i++) vecs.push_back(rd(i == 0, 1, 1, 1, 0, 1, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(rd(i == 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(rd(0, 1, 1, 1, 0, 0, 1));
    // owner 1 keeps; non-owner lock ignored; owner drop falls through
    vecs.push_back(rd(1, 0, 1, 0, 1, 0, 1));
    vecs.push_back(rd(0, 1, 1, 1, 1, 0, 1));
    vecs.push_back(rd(0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(rd(0, 1, 1, 1, 1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      if (v.rst) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
      addr0 = v.a0; wdata0 = v.d0; we0 = v.w0;
      addr1 = v.a1; wdata1 = v.d1; we1 = v.w1;
      e.g0 = v.eg0;
      e.g1 = v.eg1;
      e.addr  = v.eg0 ? v.a0 : v.eg1 ? v.a1 : 32'h0;
      e.wdata = v.eg0 ? v.d0 : v.eg1 ? v.d1 : 32'h0;
      e.we    = v.eg0 ? v.w0 : v.eg1 ? v.w1 : 4'h0;
      e.rd0   = v.eg0 ? mem[v.a0[7:2]] : 32'h0;
      e.rd1   = v.eg1 ? mem[v.a1[7:2]] : 32'h0;
      sbq.push_back(e);
      @(negedge clk);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d scoreboard: got empty expected entry", i);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d gnt0", i), {31'd0, gnt0}, {31'd0, e.g0});
        chk($sformatf("v%0d gnt1", i), {31'd0, gnt1}, {31'd0, e.g1});
        chk($sformatf("v%0d onehot", i), {31'd0, gnt0 & gnt1}, 32'd0);
        chk($sformatf("v%0d m_daddr", i), m_daddr, e.addr);
        chk($sformatf("v%0d m_dwdata", i), m_dwdata, e.wdata);
        chk($sformatf("v%0d m_dwe", i), {28'd0, m_dwe}, {28'd0, e.we});
        chk($sformatf("v%0d rdata0", i), rdata0, e.rd0);
        chk($sformatf("v%0d rdata1", i), rdata1, e.rd1);
      end
    end

    chk("mem 0x10", mem[4], 32'hDEAD5555);
    chk("mem 0x20", mem[8], 32'h12345678);
    chk("mem 0x00", mem[0], 32'hCAFEF00D);

    // reset while requester 1 owns: grant flips to 0 within the pulse
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req0 = 0; req1 = 1; lock0 = 0; lock1 = 1;
    addr1 = 32'h20; we1 = 4'h0;
    #1;
    chk("own1 first grant", {30'd0, gnt1, gnt0}, 32'd2);
    @(posedge clk);
    #1;
    req0 = 1; addr0 = 32'h10; we0 = 4'h0;
    #1;
    chk("own1 keeps", {30'd0, gnt1, gnt0}, 32'd2);
    reset = 1'b1;
    #1;
    chk("async regrant", {30'd0, gnt1, gnt0}, 32'd1);
    chk("async rdata0", rdata0, 32'hDEAD5555);
    reset = 1'b0;
    lock1 = 0;
    @(negedge clk);
    chk("post reset grant", {30'd0, gnt1, gnt0}, 32'd1);
    @(posedge clk);
    #1;
    chk("post reset alternate", {30'd0, gnt1, gnt0}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
